// File: rtl/axis_pkg.sv
// Shared constants and helpers for the stream AXI address generators.
// One-hot state encoding, page size and a clog2 helper.
package axis_pkg;

  localparam int IDLE_I  = 0;
  localparam int CALC_I  = 1;
  localparam int ISSUE_I = 2;
  localparam int DONE_I  = 3;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    CALC  = 4'b0010,
    ISSUE = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam int PAGE_BYTES = 4096;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/axis_addr_burst_calc.sv
// Burst sizing: beats = min(remaining, BURST_MAX, to4k).
// Purely combinational; shared with the read-side generator.
module axis_addr_burst_calc
  import axis_pkg::*;
#(
  parameter int CW        = 32,
  parameter int BURST_MAX = 256,
  parameter int BW        = clog2(BURST_MAX) + 1
) (
  input  logic [CW-1:0] remaining,
  input  logic [12:0]   to4k,
  output logic [BW-1:0] beats
);

  localparam int MW = (CW > 13 ? CW : 13) + 1;

  // Successively clamp the burst-max limit by page room and remaining beats
  always_comb begin
    beats = BW'(BURST_MAX);
    if (MW'(to4k) < MW'(beats))
      beats = BW'(to4k);
    if (MW'(remaining) < MW'(beats))
      beats = BW'(remaining);
  end

endmodule

// File: rtl/axis_addr_gen.sv
// AXI address-channel generator: splits one command into 4 KB-safe bursts.
// Optional in-flight burst limit: define AXIS_ADDR_GEN_OUTSTANDING_EN.
module axis_addr_gen
  import axis_pkg::*;
#(
  parameter int CONFIG_DWIDTH  = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int DATA_BYTES     = 32,
  parameter int BURST_MAX      = 256,
  parameter int OUTSTANDING    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_address,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      axi_aready,
  output logic [AXI_ID_WIDTH-1:0]   axi_aid,
  output logic [AXI_ADDR_WIDTH-1:0] axi_aaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_alen,
  output logic                      axi_avalid,
  input  logic                      cmpl,
  output logic                      done
);

  localparam int CW  = CONFIG_DWIDTH;
  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int DBL = clog2(DATA_BYTES);
  localparam int BW  = clog2(BURST_MAX) + 1;
  localparam logic [AW-1:0] ALIGN = ~AW'(DATA_BYTES - 1);

  state_t state, state_nxt;

  logic [AW-1:0]            addr_q;
  logic [CW-1:0]            rem_q;
  logic [AXI_ID_WIDTH-1:0]  aid_q;
  logic [AXI_LEN_WIDTH-1:0] alen_q;
  logic [BW-1:0]            beats_q;
  logic [BW-1:0]            beats_c;
  logic [12:0]              to4k;
  logic                     hs;
  logic                     os_ok;
  logic                     drained;

  assign to4k = (13'(PAGE_BYTES) - {1'b0, addr_q[11:0]}) >> DBL;
  assign hs   = axi_avalid & axi_aready;

  axis_addr_burst_calc #(
    .CW       (CW),
    .BURST_MAX(BURST_MAX),
    .BW       (BW)
  ) u_calc (
    .remaining(rem_q),
    .to4k     (to4k),
    .beats    (beats_c)
  );

`ifdef AXIS_ADDR_GEN_OUTSTANDING_EN
  localparam int OCW = clog2(OUTSTANDING + 1);
  logic [OCW-1:0] os_q;

  assign os_ok   = os_q < OCW'(OUTSTANDING);
  assign drained = os_q == '0;

  // In-flight burst count; simultaneous issue and completion cancel out
  always_ff @(posedge clk) begin
    if (rst)
      os_q <= '0;
    else if (hs && !cmpl)
      os_q <= os_q + 1'b1;
    else if (!hs && cmpl && os_q != '0)
      os_q <= os_q - 1'b1;
  end
`else
  logic unused_cmpl;

  assign os_ok       = 1'b1;
  assign drained     = 1'b1;
  assign unused_cmpl = cmpl | (OUTSTANDING < 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b0;
    axi_avalid = 1'b0;
    done       = 1'b0;
    unique case (1'b1)
      state[IDLE_I]: begin
        cfg_ready = 1'b1;
        if (cfg_valid)
          state_nxt = CALC;
      end
      state[CALC_I]:
        state_nxt = (rem_q == '0) ? DONE : ISSUE;
      state[ISSUE_I]: begin
        axi_avalid = os_ok;
        if (os_ok && axi_aready)
          state_nxt = CALC;
      end
      state[DONE_I]: begin
        done = drained;
        if (drained)
          state_nxt = IDLE;
      end
      default:
        state_nxt = IDLE;
    endcase
  end

  // Command latch, burst sizing and post-handshake advance
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      aid_q   <= '0;
      alen_q  <= '0;
      beats_q <= '0;
    end else begin
      if (state[IDLE_I] && cfg_valid) begin
        addr_q <= AW'(cfg_address) & ALIGN;
        rem_q  <= cfg_length;
        aid_q  <= '0;
      end
      if (state[CALC_I] && rem_q != '0) begin
        beats_q <= beats_c;
        alen_q  <= AXI_LEN_WIDTH'(beats_c - 1'b1);
      end
      if (hs) begin
        addr_q <= addr_q + (AW'(beats_q) << DBL);
        rem_q  <= rem_q - CW'(beats_q);
        aid_q  <= aid_q + 1'b1;
      end
    end
  end

  assign axi_aaddr = addr_q;
  assign axi_alen  = alen_q;
  assign axi_aid   = aid_q;

endmodule

// File: tb/tb_axis_addr_gen.sv
// Scoreboard bench for axis_addr_gen: expected bursts queued at stimulus,
// a negedge monitor pops and compares on every address handshake.
module tb_axis_addr_gen;

`ifdef AXIS_ADDR_GEN_OUTSTANDING_EN
  localparam int OUTS = 2;
`else
  localparam int OUTS = 4;
`endif

  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] cfg_address = 0;
  logic [31:0] cfg_length = 0;
  logic        cfg_valid = 0;
  logic        cfg_ready;
  logic        axi_aready = 1;
  logic [7:0]  axi_aid;
  logic [31:0] axi_aaddr;
  logic [7:0]  axi_alen;
  logic        axi_avalid;
  logic        cmpl = 0;
  logic        done;

  axis_addr_gen #(
    .CONFIG_DWIDTH (32),
    .AXI_ID_WIDTH  (8),
    .AXI_LEN_WIDTH (8),
    .AXI_ADDR_WIDTH(32),
    .DATA_BYTES    (32),
    .BURST_MAX     (256),
    .OUTSTANDING   (OUTS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_address(cfg_address),
    .cfg_length (cfg_length),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .axi_aready (axi_aready),
    .axi_aid    (axi_aid),
    .axi_aaddr  (axi_aaddr),
    .axi_alen   (axi_alen),
    .axi_avalid (axi_avalid),
    .cmpl       (cmpl),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
  } burst_t;

  burst_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int cmpl_given = 0;
  int man_req = 0;
  int man_done = 0;
  bit auto_cmpl = 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] l,
                      input logic [7:0] i);
    burst_t b;
    b.addr = a;
    b.len  = l;
    b.id   = i;
    exp_q.push_back(b);
  endtask

  logic        stall_prev = 0;
  logic [31:0] p_addr;
  logic [7:0]  p_len;
  logic [7:0]  p_id;

  always @(negedge clk) begin
    burst_t b;
    if (!rst && stall_prev) begin
      chk("stall_avalid", axi_avalid, 1);
      chk("stall_addr", axi_aaddr, p_addr);
      chk("stall_len", axi_alen, p_len);
      chk("stall_id", axi_aid, p_id);
    end
    if (!rst && axi_avalid && axi_aready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_burst", axi_aaddr, 32'hffff_ffff);
      end else begin
        b = exp_q.pop_front();
        chk("burst_addr", axi_aaddr, b.addr);
        chk("burst_len", axi_alen, b.len);
        chk("burst_id", axi_aid, b.id);
      end
    end
    stall_prev = axi_avalid && !axi_aready;
    p_addr = axi_aaddr;
    p_len  = axi_alen;
    p_id   = axi_aid;
    if (done) done_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      cmpl_given = hs_cnt;
      cmpl = 0;
    end else if (auto_cmpl ? (cmpl_given < hs_cnt) : (man_done < man_req)) begin
      cmpl = 1;
      cmpl_given++;
      if (!auto_cmpl) man_done++;
    end else begin
      cmpl = 0;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] l);
    @(posedge clk); #1;
    cfg_address = a;
    cfg_length  = l;
    cfg_valid   = 1;
    @(negedge clk);
    chk("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk); #1;
    cfg_valid = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    bit seen;
    start = done_cnt;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #2;
      if (done_cnt != start) seen = 1;
    end
    chk({name, "_done"}, seen, 1);
    @(posedge clk); #2;
    chk({name, "_done_once"}, done_cnt - start, 1);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_avalid(input string name, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #2;
      if (axi_avalid) seen = 1;
    end
    chk({name, "_avalid_seen"}, seen, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int h0;
    int d0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_avalid", axi_avalid, 0);
    chk("rst_aid", axi_aid, 0);
    chk("rst_aaddr", axi_aaddr, 0);
    chk("rst_alen", axi_alen, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 0;

    // 600 beats from page start: four full-page bursts then 88 beats
    push(32'h0000, 127, 0);
    push(32'h1000, 127, 1);
    push(32'h2000, 127, 2);
    push(32'h3000, 127, 3);
    push(32'h4000, 87, 4);
    send(32'h0000, 600);
    @(negedge clk);
    chk("lat_c1_avalid", axi_avalid, 0);
    @(negedge clk);
    chk("lat_c2_avalid", axi_avalid, 1);
    wait_done("len600", 200);

    // Page-crossing split; extra cfg_valid while busy is ignored
    push(32'h0FC0, 1, 0);
    push(32'h1000, 7, 1);
    send(32'h0FC0, 10);
    cfg_address = 32'h5000;
    cfg_length  = 3;
    cfg_valid   = 1;
    @(negedge clk);
    chk("busy_cfg_ready", cfg_ready, 0);
    @(negedge clk);
    chk("busy_cfg_ready2", cfg_ready, 0);
    @(posedge clk); #1;
    cfg_valid = 0;
    wait_done("cross4k", 50);

    // Zero length: no burst, done at cycle 2, ready at cycle 3
    h0 = hs_cnt;
    send(32'h0040, 0);
    @(negedge clk);
    chk("len0_c1_done", done, 0);
    @(negedge clk);
    chk("len0_c2_done", done, 1);
    chk("len0_c2_ready", cfg_ready, 0);
    chk("len0_c2_avalid", axi_avalid, 0);
    @(negedge clk);
    chk("len0_c3_ready", cfg_ready, 1);
    chk("len0_c3_done", done, 0);
    chk("len0_no_burst", hs_cnt - h0, 0);

    // Back-pressure: outputs held while axi_aready stays low
    h0 = hs_cnt;
    axi_aready = 0;
    push(32'h0000, 4, 0);
    send(32'h001F, 5);
    @(negedge clk);
    @(negedge clk);
    chk("stall_c2_avalid", axi_avalid, 1);
    repeat (5) @(negedge clk);
    chk("stall_no_hs", hs_cnt - h0, 0);
    @(posedge clk); #1;
    axi_aready = 1;
    wait_done("stall", 50);
    chk("stall_one_hs", hs_cnt - h0, 1);

`ifdef AXIS_ADDR_GEN_OUTSTANDING_EN
    // In-flight limit of two with completions under bench control
    auto_cmpl = 0;
    h0 = hs_cnt;
    d0 = done_cnt;
    push(32'h0000, 127, 0);
    push(32'h1000, 127, 1);
    push(32'h2000, 127, 2);
    push(32'h3000, 127, 3);
    send(32'h0000, 512);
    idle_cycles(12);
    chk("os_two_hs", hs_cnt - h0, 2);
    chk("os_blocked", axi_avalid, 0);
    man_req++;
    idle_cycles(8);
    chk("os_third_hs", hs_cnt - h0, 3);
    chk("os_blocked2", axi_avalid, 0);
    man_req++;
    idle_cycles(8);
    chk("os_fourth_hs", hs_cnt - h0, 4);
    man_req++;
    idle_cycles(6);
    chk("os_no_done_early", done_cnt - d0, 0);
    man_req++;
    wait_done("os_drain", 20);
    auto_cmpl = 1;
`endif

    // Reset during the second burst of a 600-beat command
    d0 = done_cnt;
    axi_aready = 0;
    push(32'h0000, 127, 0);
    send(32'h0000, 600);
    wait_avalid("rst_b1", 10);
    axi_aready = 1;
    @(posedge clk); #1;
    axi_aready = 0;
    wait_avalid("rst_b2", 10);
    chk("rst_b2_aid", axi_aid, 1);
    chk("rst_b2_aaddr", axi_aaddr, 32'h1000);
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_avalid", axi_avalid, 0);
    chk("midrst_ready", cfg_ready, 1);
    chk("midrst_aaddr", axi_aaddr, 0);
    chk("midrst_sb", exp_q.size(), 0);
    @(posedge clk); #1;
    rst = 0;
    axi_aready = 1;
    chk("midrst_no_done", done_cnt - d0, 0);
    push(32'h0100, 3, 0);
    send(32'h0100, 4);
    wait_done("after_rst", 50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
